// File: rtl/jump_flush_ctrl.sv
// jump_flush_ctrl: inserts FLUSH_DEPTH bubbles per accepted redirect, then one guard cycle, with saturating stats.
module jump_flush_ctrl #(
  parameter int FLUSH_DEPTH = 1,
  parameter int NUM_SRC = 2,
  parameter int CNT_W = 32,
  localparam int SW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] redirect_req,
  input  logic               stall,
  input  logic               clr_stats,
  output logic               bubble,
  output logic               busy,
  output logic [SW-1:0]      src_id,
  output logic [CNT_W-1:0]   redirect_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);
  typedef enum logic [1:0] {IDLE, FLUSH, GUARD} state_t;
  state_t state, state_nx;
  logic [3:0] rem, rem_nx;
  logic [SW-1:0] win;
  logic accept;
  always_comb begin
    win = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (redirect_req[i]) win = SW'(i);
  end
  assign accept = state == IDLE && !rst && !stall && |redirect_req;
  assign bubble = !rst && (accept || state == FLUSH);
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state;
    rem_nx = rem;
    if (accept) begin
      state_nx = FLUSH_DEPTH == 1 ? GUARD : FLUSH;
      rem_nx = 4'(FLUSH_DEPTH - 1);
    end else if (!stall && state == FLUSH) begin
      state_nx = rem == 4'd1 ? GUARD : FLUSH;
      rem_nx = rem - 4'd1;
    end else if (!stall && state == GUARD) begin
      state_nx = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rem <= '0;
      src_id <= '0;
      redirect_cnt <= '0;
      bubble_cnt <= '0;
    end else begin
      state <= state_nx;
      rem <= rem_nx;
      if (accept) src_id <= win;
      redirect_cnt <= clr_stats ? '0 : (accept && ~&redirect_cnt) ? redirect_cnt + 1'b1 : redirect_cnt;
      bubble_cnt <= clr_stats ? '0 : (bubble && !stall && ~&bubble_cnt) ? bubble_cnt + 1'b1 : bubble_cnt;
    end
  end
endmodule
